// File: rtl/sr_pattern_driver.sv
// Turns a requested WIDTH-bit Q sequence into minimal S/R commands for one SR flop.
// It also checks the flop's Q against the request, two edges after each command.
module sr_pattern_driver #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1),
  localparam int IW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic             q_fb,
  output logic             S,
  output logic             R,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [IW-1:0]    mismatch_idx,
  output logic [CW-1:0]    set_count,
  output logic [CW-1:0]    reset_count
);

  typedef enum logic [1:0] {IDLE, DRIVE, FLUSH} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   pat_sh;
  logic [CW-1:0]      bit_idx;
  logic               exp_q;

  logic               drv_en, want, set_cmd, rst_cmd, accept;
  logic [IW-1:0]      drv_idx;

  // Stage 0 holds the bit just commanded; stage 1 is the bit the flop has
  // already captured, so it is the one compared with q_fb.
  logic [1:0]         vld_pipe;
  logic [1:0][IW-1:0] idx_pipe;
  logic [1:0]         want_pipe;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DRIVE;
      DRIVE:   if (bit_idx == CW'(WIDTH)) state_nxt = FLUSH;
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bit 0 goes out on the accepting edge itself, straight from the input.
  always_comb begin
    drv_en  = 1'b0;
    want    = 1'b0;
    drv_idx = '0;
    accept  = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept = 1'b1;
        drv_en = 1'b1;
        want   = pattern[0];
      end
      DRIVE: if (bit_idx != CW'(WIDTH)) begin
        drv_en  = 1'b1;
        want    = pat_sh[0];
        drv_idx = bit_idx[IW-1:0];
      end
      default: ;
    endcase
    set_cmd = drv_en &&  want && !exp_q;
    rst_cmd = drv_en && !want &&  exp_q;
    busy    = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      S            <= 1'b0;
      R            <= 1'b0;
      done         <= 1'b0;
      exp_q        <= 1'b0;
      pat_sh       <= '0;
      bit_idx      <= '0;
      set_count    <= '0;
      reset_count  <= '0;
      mismatch     <= 1'b0;
      mismatch_idx <= '0;
      vld_pipe     <= '0;
      idx_pipe     <= '0;
      want_pipe    <= '0;
    end else begin
      S         <= set_cmd;
      R         <= rst_cmd;
      done      <= (state == FLUSH);
      vld_pipe  <= {vld_pipe[0], drv_en};
      idx_pipe  <= {idx_pipe[0], drv_idx};
      want_pipe <= {want_pipe[0], want};
      if (drv_en) exp_q <= want;

      if (accept) begin
        pat_sh       <= pattern >> 1;
        bit_idx      <= CW'(1);
        set_count    <= CW'(set_cmd);
        reset_count  <= CW'(rst_cmd);
        mismatch     <= 1'b0;
        mismatch_idx <= '0;
      end else begin
        if (drv_en) begin
          pat_sh  <= pat_sh >> 1;
          bit_idx <= bit_idx + CW'(1);
        end
        if (set_cmd) set_count   <= set_count + CW'(1);
        if (rst_cmd) reset_count <= reset_count + CW'(1);
        // Only the first failing bit is recorded.
        if (vld_pipe[1] && (q_fb != want_pipe[1]) && !mismatch) begin
          mismatch     <= 1'b1;
          mismatch_idx <= idx_pipe[1];
        end
      end
    end
  end

endmodule

// File: doc/sr_pattern_driver.md
Name: sr_pattern_driver

Overview:
- Command-side counterpart to the team's SR flip-flop: converts a requested WIDTH-bit Q sequence into minimal S/R commands.
- Drives the flop's S/R inputs and checks its Q output against the requested sequence.
- Sits between a control FSM (start/pattern) and one SR flip-flop sharing the same clk/rst.
- Never issues the invalid S=R=1 command.

Parameters:
WIDTH, 8, number of pattern bits driven per operation (>=2); bit 0 is driven first.
CW, $clog2(WIDTH+1), width of command counters (derived, not overridden).
IW, $clog2(WIDTH), width of mismatch index (derived).

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  reset, synchronous, active-high.
start  in  1  request pulse; accepted only in IDLE.
pattern  in  WIDTH  requested Q sequence, sampled when start accepted.
q_fb  in  1  Q output of the driven SR flip-flop.
S  out  1  set command to flop (registered).
R  out  1  reset command to flop (registered).
busy  out  1  high while an operation is in progress.
done  out  1  one-cycle pulse at operation completion.
mismatch  out  1  sticky: any checked bit differed; cleared on accepted start.
mismatch_idx  out  IW  index of first mismatching bit; valid when mismatch=1.
set_count  out  CW  S commands issued in current/last operation.
reset_count  out  CW  R commands issued in current/last operation.

Behaviour:
- Reset (rst=1 at edge): state IDLE, S=0, R=0, busy=0, done=0, mismatch=0, mismatch_idx=0, set_count=0, reset_count=0, exp_q=0. exp_q is the internal model of flop Q; it matches the flop's own reset value of 0.
- States:
  - IDLE: start=1 at edge k -> latch pattern, clear counts/mismatch/mismatch_idx, go to DRIVE with bit index 0.
  - DRIVE: WIDTH cycles, one per bit.
  - FLUSH: 1 cycle, final check.
  - Then return to IDLE with done=1.
- Drive rule for bit i, registered at edge k+i:
  - want=pattern[i]. If want==exp_q: S=0,R=0.
  - If want=1,exp_q=0: S=1, set_count+1.
  - If want=0,exp_q=1: R=1, reset_count+1.
  - exp_q<=want.
  - S and R are one-hot or zero, never both 1.
- Check rule:
  - The flop captures bit i at edge k+i+1, so q_fb is compared with pattern[i] at edge k+i+2, for i=0..WIDTH-1.
  - Checks overlap with DRIVE. The last check occurs in FLUSH.
  - On the first mismatch: mismatch<=1, mismatch_idx<=i. Later mismatches do not change mismatch_idx.
  - The operation continues to completion; there is no abort.
- Timing:
  - busy=1 during cycles after edges k .. k+WIDTH.
  - done=1 and busy=0 during the cycle after edge k+WIDTH+1.
  - S=R=0 in FLUSH and IDLE.
- start while busy: ignored, with no effect on state or outputs. start during the done cycle: accepted (state is IDLE).
- exp_q persists across operations, like the flop. A repeated pattern therefore needs no command on bit 0 if it already equals Q.
- Counters, mismatch and mismatch_idx hold their values after done until the next accepted start or rst.
- rst mid-operation: immediate return to IDLE, all outputs and exp_q at reset values next cycle, no done pulse. The shared rst also clears the flop, so the model stays coherent.
- Counter range: max count is WIDTH. CW bits cover it; no wrap.

Test Plan:
1. rst, then start with pattern=8'h00 -> S=R=0 throughout; set_count=0, reset_count=0; done 10 cycles after start edge; busy high 9 cycles; mismatch=0.
2. pattern=8'b0101_0101 with exp_q=0 -> S on bits 0,2,4,6 and R on bits 1,3,5,7; set_count=4, reset_count=4; no mismatch with a correct flop model.
3. Back-to-back ops:
   - 8'hFF from exp_q=0 -> set_count=1.
   - Start in the done cycle with 8'hFF -> set_count=0, reset_count=0.
   - Then 8'h00 -> reset_count=1, R only on bit 0.
4. Stuck-at-0 flop (q_fb=0) with pattern=8'b0000_0100 -> mismatch=1, mismatch_idx=2, set_count=1, reset_count=1; done at the nominal cycle.
5. rst asserted during bit 3 of pattern 8'hAA -> next cycle busy=0, S=R=0, counts=0, no done. Following start with 8'h01 -> set_count=1, reset_count=1, mismatch=0.
6. start pulsed every cycle of an 8'h0F operation -> only the first start and the start in the done cycle are accepted. Assertion S&R==0 holds in all scenarios.
